// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 max-pooling down-sampler for channel-interleaved pixel streams.
// The horizontal max goes through a hold register; the even-row result is parked in a line buffer.
module max_pool_2x2 #(
  parameter int DATA_WIDTH   = 8,
  parameter int STRING_LEN   = 224,
  parameter int CHANNEL_NUM  = 3,
  parameter int DATA_O_WIDTH = DATA_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic signed [DATA_WIDTH-1:0]   data_i,
  input  logic                           valid_i,
  input  logic                           sop_i,
  input  logic                           eop_i,
  input  logic                           sof_i,
  input  logic                           eof_i,
  output logic signed [DATA_O_WIDTH-1:0] data_o,
  output logic                           data_valid_o,
  output logic                           sop_o,
  output logic                           eop_o,
  output logic                           sof_o,
  output logic                           eof_o
);

  localparam int PAIRS = STRING_LEN / 2;
  localparam int DEPTH = PAIRS * CHANNEL_NUM;
  localparam int CW    = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
  localparam int XW    = (STRING_LEN > 2) ? $clog2(STRING_LEN) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DATA_O_WIDTH != DATA_WIDTH) begin : g_bad_width
    $error("max_pool_2x2: DATA_O_WIDTH must equal DATA_WIDTH");
  end
  if ((STRING_LEN % 2) != 0 || STRING_LEN < 2) begin : g_bad_len
    $error("max_pool_2x2: STRING_LEN must be even and at least 2");
  end
  if (CHANNEL_NUM < 1) begin : g_bad_chan
    $error("max_pool_2x2: CHANNEL_NUM must be at least 1");
  end

  logic [CW-1:0] chan_q, chan_e, chan_n;
  logic [XW-1:0] col_q, col_e, col_n, pair_e;
  logic          rp_q, rp_e, rp_n;
  logic          sof_pend_q;
  logic          last_chan, last_col;
  logic [AW-1:0] addr_e;
  logic          wr_en, rd_en;

  logic signed [DATA_WIDTH-1:0] hold [CHANNEL_NUM];
  logic signed [DATA_WIDTH-1:0] ram  [DEPTH];
  logic signed [DATA_WIDTH-1:0] hold_sel, hmax, ram_q, hmax_r, pooled;

  logic s1_valid, s1_sop, s1_eop, s1_sof, s1_eof;
  logic unused_inputs;

  // End of row is implied by the counters; eop_i carries no extra information.
  assign unused_inputs = eop_i;

  // Effective position of the current sample after sof/sop resync, and the position that follows it.
  always_comb begin
    chan_e = chan_q;
    col_e  = col_q;
    rp_e   = rp_q;
    if (sof_i) begin
      chan_e = '0;
      col_e  = '0;
      rp_e   = 1'b0;
    end else if (sop_i) begin
      chan_e = '0;
      col_e  = '0;
    end
    last_chan = (chan_e == CW'(CHANNEL_NUM - 1));
    last_col  = (col_e == XW'(STRING_LEN - 1));
    chan_n    = last_chan ? '0 : chan_e + 1'b1;
    col_n     = col_e;
    if (last_chan) col_n = last_col ? '0 : col_e + 1'b1;
    rp_n      = rp_e ^ (last_chan & last_col);
    if (eof_i) rp_n = 1'b0;
    pair_e    = col_e >> 1;
    addr_e    = AW'(int'(pair_e) * CHANNEL_NUM + int'(chan_e));
    hold_sel  = hold[chan_e];
    hmax      = (hold_sel > data_i) ? hold_sel : data_i;
    wr_en     = valid_i & col_e[0] & ~rp_e;
    rd_en     = valid_i & col_e[0] & rp_e;
    pooled    = (hmax_r > ram_q) ? hmax_r : ram_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chan_q     <= '0;
      col_q      <= '0;
      rp_q       <= 1'b0;
      sof_pend_q <= 1'b0;
    end else if (valid_i) begin
      chan_q <= chan_n;
      col_q  <= col_n;
      rp_q   <= rp_n;
      if (sof_i)      sof_pend_q <= 1'b1;
      else if (rd_en) sof_pend_q <= 1'b0;
    end
  end

  // Storage without reset: contents are always written before they are read.
  always_ff @(posedge clk) begin
    if (valid_i && !col_e[0]) hold[chan_e] <= data_i;
    if (wr_en) ram[addr_e] <= hmax;
    if (rd_en) ram_q <= ram[addr_e];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      hmax_r   <= '0;
      s1_sop   <= 1'b0;
      s1_eop   <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eof   <= 1'b0;
    end else begin
      s1_valid <= rd_en;
      if (rd_en) begin
        hmax_r <= hmax;
        s1_sop <= (pair_e == '0) && (chan_e == '0);
        s1_eop <= (pair_e == XW'(PAIRS - 1)) && last_chan;
        s1_sof <= sof_pend_q && (pair_e == '0) && (chan_e == '0);
        s1_eof <= eof_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_o       <= '0;
      data_valid_o <= 1'b0;
      sop_o        <= 1'b0;
      eop_o        <= 1'b0;
      sof_o        <= 1'b0;
      eof_o        <= 1'b0;
    end else begin
      data_valid_o <= s1_valid;
      sop_o        <= s1_valid & s1_sop;
      eop_o        <= s1_valid & s1_eop;
      sof_o        <= s1_valid & s1_sof;
      eof_o        <= s1_valid & s1_eof;
      if (s1_valid) data_o <= pooled;
    end
  end

endmodule
